// File: rtl/data_mem_responder.sv
// Data-memory responder: one load/store per transaction with fixed wait-state latency.
// Optional MEM_MISALIGN_ERR_EN flags misaligned half/word accesses on resp_err.
module data_mem_responder #(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic                  req_we,
  input  logic [1:0]            req_size,
  input  logic                  req_sign,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  resp_err
);

  localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);
  localparam int unsigned CNT_W = 4;
  localparam logic [CNT_W-1:0] CNT_INIT =
    (WAIT_CYCLES == 0) ? '0 : CNT_W'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACCESS, S_RESP} state_t;

  typedef struct packed {
    logic [IDX_W-1:0]      idx;
    logic [1:0]            lane;
    logic                  we;
    logic [1:0]            size;
    logic                  sign;
    logic [DATA_WIDTH-1:0] wdata;
  } req_t;

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q;
  req_t                  req_q;
  logic [DATA_WIDTH-1:0] mem [DEPTH_WORDS];
  logic [DATA_WIDTH-1:0] rd_word;
  logic [7:0]            rd_byte;
  logic [15:0]           rd_half;
  logic [DATA_WIDTH-1:0] ext_data;
  logic [DATA_WIDTH-1:0] wr_data;
  logic [3:0]            be;
  logic                  misalign;
  logic                  unused_addr;

  assign req_ready   = (state_q == S_IDLE);
  assign unused_addr = ^req_addr[ADDR_WIDTH-1:IDX_W+2];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (req_valid) state_d = (WAIT_CYCLES > 0) ? S_WAIT : S_ACCESS;
      S_WAIT:   if (cnt_q == '0) state_d = S_ACCESS;
      S_ACCESS: state_d = S_RESP;
      S_RESP:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Request capture and wait-state counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_q <= '0;
      cnt_q <= '0;
    end else if (req_valid && req_ready) begin
      req_q <= '{idx:   req_addr[2 +: IDX_W],
                 lane:  req_addr[1:0],
                 we:    req_we,
                 size:  req_size,
                 sign:  req_sign,
                 wdata: req_wdata};
      cnt_q <= CNT_INIT;
    end else if (state_q == S_WAIT && cnt_q != '0) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

`ifdef MEM_MISALIGN_ERR_EN
  assign misalign = ((req_q.size == 2'b01) && req_q.lane[0]) ||
                    (req_q.size[1] && (req_q.lane != 2'b00));
`else
  assign misalign = 1'b0;
`endif

  // Store lane enables with data replicated across lanes
  always_comb begin
    be      = 4'b1111;
    wr_data = req_q.wdata;
    case (req_q.size)
      2'b00: begin
        be      = 4'b0001 << req_q.lane;
        wr_data = {4{req_q.wdata[7:0]}};
      end
      2'b01: begin
        be      = req_q.lane[1] ? 4'b1100 : 4'b0011;
        wr_data = {2{req_q.wdata[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    rd_word  = mem[req_q.idx];
    rd_byte  = rd_word[{req_q.lane, 3'b000} +: 8];
    rd_half  = rd_word[{req_q.lane[1], 4'b0000} +: 16];
    ext_data = rd_word;
    case (req_q.size)
      2'b00:   ext_data = {{(DATA_WIDTH-8){req_q.sign & rd_byte[7]}}, rd_byte};
      2'b01:   ext_data = {{(DATA_WIDTH-16){req_q.sign & rd_half[15]}}, rd_half};
      default: ext_data = rd_word;
    endcase
  end

  // Array is not reset; stores commit at the end of ACCESS
  always_ff @(posedge clk) begin
    if (state_q == S_ACCESS && req_q.we && !misalign) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[req_q.idx][8*i +: 8] <= wr_data[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_valid <= 1'b0;
      resp_rdata <= '0;
    end else begin
      resp_valid <= (state_q == S_ACCESS);
      if (state_q == S_ACCESS) resp_rdata <= (req_q.we || misalign) ? '0 : ext_data;
    end
  end

`ifdef MEM_MISALIGN_ERR_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) resp_err <= 1'b0;
    else        resp_err <= (state_q == S_ACCESS) && misalign;
  end
`else
  assign resp_err = 1'b0;
`endif

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: vector table driven through a response scoreboard,
// plus reset-abort and continuous-valid sequences.
module tb_data_mem_responder;

  localparam int unsigned WAIT_CYCLES = 2;
  localparam int unsigned NVEC = 24;
  localparam int unsigned SPLIT = 18;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_sign;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;

  data_mem_responder #(
    .DATA_WIDTH(32), .ADDR_WIDTH(32), .DEPTH_WORDS(1024), .WAIT_CYCLES(WAIT_CYCLES)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_we(req_we), .req_size(req_size), .req_sign(req_sign), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        sign;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int unsigned cyc;
  } exp_t;

  vec_t        vecs [NVEC];
  exp_t        exp_q [$];
  int unsigned cyc = 0;
  int          n_checks = 0;
  int          n_pass = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Response monitor: every pulse must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (resp_valid) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_resp: got resp_valid=1 expected no response (cycle %0d)", cyc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("resp_rdata", resp_rdata, e.rdata);
        check("resp_err", 32'(resp_err), 32'(e.err));
        check("latency", cyc - e.cyc, WAIT_CYCLES + 2);
      end
    end
  end

  task automatic drain(input string name);
    for (int k = 0; k < 40 && exp_q.size() != 0; k++) @(negedge clk);
    if (exp_q.size() != 0) begin
      n_checks++;
      $display("FAIL %s_timeout: got %0d outstanding expected 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic do_txn(input vec_t v);
    exp_t e;
    int   k;
    @(negedge clk);
    for (k = 0; k < 20 && !req_ready; k++) @(negedge clk);
    check("ready_before_req", 32'(req_ready), 32'd1);
    req_addr  = v.addr;
    req_we    = v.we;
    req_size  = v.size;
    req_sign  = v.sign;
    req_wdata = v.wdata;
    req_valid = 1'b1;
    e.rdata = v.exp_rdata;
    e.err   = v.exp_err;
    e.cyc   = cyc;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    check("ready_low_after_accept", 32'(req_ready), 32'd0);
    drain("txn");
  endtask

  initial begin
    int   accepts;
    int unsigned prev_cyc;
    exp_t e;
    vec_t v;

    // we, size, sign, addr, wdata, exp_rdata, exp_err
    vecs[0]  = '{1'b1, 2'b10, 1'b0, 32'h10,   32'hDEADBEEF, 32'h0,        1'b0};
    vecs[1]  = '{1'b0, 2'b10, 1'b0, 32'h10,   32'h0,        32'hDEADBEEF, 1'b0};
    vecs[2]  = '{1'b1, 2'b10, 1'b0, 32'h10,   32'h11223344, 32'h0,        1'b0};
    vecs[3]  = '{1'b1, 2'b00, 1'b0, 32'h13,   32'hFFFFFF80, 32'h0,        1'b0};
    vecs[4]  = '{1'b0, 2'b00, 1'b1, 32'h13,   32'h0,        32'hFFFFFF80, 1'b0};
    vecs[5]  = '{1'b0, 2'b00, 1'b0, 32'h13,   32'h0,        32'h00000080, 1'b0};
    vecs[6]  = '{1'b0, 2'b10, 1'b0, 32'h10,   32'h0,        32'h80223344, 1'b0};
    vecs[7]  = '{1'b0, 2'b00, 1'b1, 32'h10,   32'h0,        32'h00000044, 1'b0};
    vecs[8]  = '{1'b0, 2'b01, 1'b1, 32'h12,   32'h0,        32'hFFFF8022, 1'b0};
    vecs[9]  = '{1'b0, 2'b01, 1'b0, 32'h10,   32'h0,        32'h00003344, 1'b0};
    vecs[10] = '{1'b1, 2'b10, 1'b0, 32'h20,   32'h0,        32'h0,        1'b0};
    vecs[11] = '{1'b1, 2'b01, 1'b0, 32'h22,   32'h1234BEEF, 32'h0,        1'b0};
    vecs[12] = '{1'b0, 2'b01, 1'b1, 32'h22,   32'h0,        32'hFFFFBEEF, 1'b0};
    vecs[13] = '{1'b0, 2'b01, 1'b0, 32'h22,   32'h0,        32'h0000BEEF, 1'b0};
    vecs[14] = '{1'b0, 2'b10, 1'b0, 32'h20,   32'h0,        32'hBEEF0000, 1'b0};
    vecs[15] = '{1'b0, 2'b11, 1'b1, 32'h20,   32'h0,        32'hBEEF0000, 1'b0};
    vecs[16] = '{1'b0, 2'b10, 1'b0, 32'h1010, 32'h0,        32'h80223344, 1'b0};
    vecs[17] = '{1'b1, 2'b10, 1'b0, 32'h40,   32'h0,        32'h0,        1'b0};
`ifdef MEM_MISALIGN_ERR_EN
    vecs[18] = '{1'b1, 2'b10, 1'b0, 32'h41,   32'h12345678, 32'h0,        1'b1};
    vecs[19] = '{1'b0, 2'b10, 1'b0, 32'h40,   32'h0,        32'h0,        1'b0};
    vecs[20] = '{1'b0, 2'b01, 1'b1, 32'h11,   32'h0,        32'h0,        1'b1};
`else
    vecs[18] = '{1'b1, 2'b10, 1'b0, 32'h41,   32'h12345678, 32'h0,        1'b0};
    vecs[19] = '{1'b0, 2'b10, 1'b0, 32'h40,   32'h0,        32'h12345678, 1'b0};
    vecs[20] = '{1'b0, 2'b01, 1'b1, 32'h11,   32'h0,        32'h00003344, 1'b0};
`endif
    vecs[21] = '{1'b1, 2'b00, 1'b0, 32'h21,   32'h000000AA, 32'h0,        1'b0};
    vecs[22] = '{1'b0, 2'b10, 1'b0, 32'h20,   32'h0,        32'hBEEFAA00, 1'b0};
    vecs[23] = '{1'b0, 2'b00, 1'b1, 32'h21,   32'h0,        32'hFFFFFFAA, 1'b0};

    rst_n = 1'b0; req_valid = 1'b0; req_addr = '0; req_we = 1'b0;
    req_size = 2'b00; req_sign = 1'b0; req_wdata = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("reset_ready", 32'(req_ready), 32'd1);
    check("reset_resp_valid", 32'(resp_valid), 32'd0);
    check("reset_resp_rdata", resp_rdata, 32'h0);
    check("reset_resp_err", 32'(resp_err), 32'd0);

    for (int i = 0; i < int'(SPLIT); i++) do_txn(vecs[i]);

    // Reset during WAIT of a store must abandon it
    @(negedge clk);
    req_addr = 32'h40; req_we = 1'b1; req_size = 2'b10; req_wdata = 32'hCAFEF00D;
    req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_ready", 32'(req_ready), 32'd1);
    check("abort_resp_valid", 32'(resp_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    v = '{1'b0, 2'b10, 1'b0, 32'h40, 32'h0, 32'h0, 1'b0};
    do_txn(v);

    for (int i = int'(SPLIT); i < int'(NVEC); i++) do_txn(vecs[i]);

    // Continuous req_valid: one accept every WAIT_CYCLES+3 cycles, one pulse each
    accepts = 0;
    prev_cyc = 0;
    @(negedge clk);
    req_addr = 32'h10; req_we = 1'b0; req_size = 2'b10; req_sign = 1'b0;
    req_valid = 1'b1;
    for (int k = 0; k < 60 && accepts < 3; k++) begin
      if (k > 0) @(negedge clk);
      if (req_ready) begin
        e.rdata = 32'h80223344;
        e.err   = 1'b0;
        e.cyc   = cyc;
        exp_q.push_back(e);
        if (accepts > 0) check("accept_gap", cyc - prev_cyc, WAIT_CYCLES + 3);
        prev_cyc = cyc;
        accepts++;
      end
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    check("hold_accepts", 32'(accepts), 32'd3);
    drain("hold");
    repeat (6) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
